seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The module SHALL have parameter REFRESH_DIV, default 50000, giving the iClk cycles each digit is driven (legal range 2..2^20).
REQ-002 The module SHALL have parameter ACTIVE_LOW, default 1; when 1, the segment and digit-enable outputs are active-low.
REQ-003 iClk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 iRst  input  1  reset, asynchronous, active-high.
REQ-005 iValue  input  16  four hex nibbles to display; nibble k drives digit k, with digit 0 = iValue[3:0].
REQ-006 iDP  input  4  decimal-point request per digit; bit k applies to digit k.
REQ-007 iLoad  input  1  single-cycle strobe that captures iValue and iDP.
REQ-008 iBlankLZ  input  1  leading-zero blanking enable, sampled every cycle.
REQ-009 oDigi  output  12  registered display bus: [11:8] digit enables (bit 8 = digit 0), [7:0] segments {dp,g,f,e,d,c,b,a}.
REQ-010 oFrame  output  1  registered one-cycle pulse marking a display-register commit.

Function
REQ-011 A divider counter SHALL count 0..REFRESH_DIV-1 and wrap; a tick occurs on the cycle the counter equals REFRESH_DIV-1.
REQ-012 On each tick, the digit index SHALL advance 0->1->2->3->0.
REQ-013 On iLoad=1, iValue and iDP SHALL be captured into a shadow register, and a pending flag SHALL be set.
REQ-014 On the tick where the index wraps 3->0 with pending=1, the display register SHALL take the shadow contents, pending SHALL clear, and oFrame SHALL pulse on the following cycle.
REQ-015 If iLoad coincides with a commit tick, the display register SHALL take the prior shadow contents, the shadow SHALL take the new data, and pending SHALL remain 1.
REQ-016 With no pending data, the display register SHALL hold, and oFrame SHALL stay 0.
REQ-017 oDigi SHALL reflect the new index and the current display register on the cycle after the tick; exactly one digit enable SHALL be active at any time.
REQ-018 Active-high segment codes SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; dp is bit 7.
REQ-019 When ACTIVE_LOW=1, all 12 oDigi bits SHALL be inverted relative to the active-high encoding.
REQ-020 With iBlankLZ=1, digit k (k>=1) SHALL be blanked (segments a-g off) when nibble k and all higher nibbles are 0.
REQ-021 A blanked digit SHALL still show dp if its iDP bit is set; digit 0 SHALL never be blanked.
REQ-022 iLoad SHALL never alter the digit index or the divider counter.

Reset
REQ-023 iRst=1 SHALL asynchronously clear the counter, index, shadow, display register, and pending flag, and set oFrame=0.
REQ-024 During reset, oDigi SHALL be 12'hEC0 (ACTIVE_LOW=1: digit 0 showing '0', dp off).
REQ-025 Reset asserted mid-scan or mid-pending SHALL discard the pending data.
REQ-026 After release, scanning SHALL restart from digit 0, with the first tick REFRESH_DIV cycles later.

Verification (REFRESH_DIV=4, ACTIVE_LOW=1)
REQ-027 Reset, then run 16 cycles -> oDigi sequence EC0, DC0, BC0, 7C0, each held 4 cycles.
REQ-028 Load 16'h12AF with iDP=0 mid-frame -> the display is unchanged until the 3->0 wrap, oFrame pulses once, then oDigi shows E8E, D88, BA4, 7F9.
REQ-029 Load 16'h0007 with iBlankLZ=1 and iDP=4'b0100 -> after commit, oDigi shows EF8, DFF, B7F, 7FF.
REQ-030 Load A on the commit tick while B is pending -> B is displayed that frame, A is displayed the next frame, and oFrame pulses twice total.
REQ-031 Assert iRst while digit 2 is active with a load pending -> oDigi=EC0 immediately; after release, the old shadow is never displayed and oFrame stays 0.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Display-side bus for seg7_scan: load/data inputs and the registered scan outputs.
interface seg7_scan_if;
    logic [15:0] iValue;
    logic [3:0]  iDP;
    logic        iLoad;
    logic        iBlankLZ;
    logic [11:0] oDigi;
    logic        oFrame;

    // Host side drives data and strobes, observes the display bus.
    modport master (
        output iValue, iDP, iLoad, iBlankLZ,
        input  oDigi, oFrame
    );

    // Display controller side.
    modport slave (
        input  iValue, iDP, iLoad, iBlankLZ,
        output oDigi, oFrame
    );
endinterface

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner with a shadow/display register pair.
// New data is latched into the shadow on iLoad and only reaches the display
// at the end of a full scan (index wrap 3->0), so a frame never tears.
module seg7_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1
) (
    input logic       iClk,
    input logic       iRst,
    seg7_scan_if.slave bus
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    // Digit 0 enabled showing '0', dp off, in the selected polarity.
    localparam logic [11:0] DIGI_RST = ACTIVE_LOW ? 12'hEC0 : 12'h13F;

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [15:0]      shadow_val, shadow_val_nxt;
    logic [3:0]       shadow_dp, shadow_dp_nxt;
    logic [15:0]      disp_val, disp_val_nxt;
    logic [3:0]       disp_dp, disp_dp_nxt;
    logic             pending, pending_nxt;
    logic             tick, commit;
    logic [11:0]      digi, digi_nxt;
    logic             frame;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0: seg_code = 7'h3F;
            4'h1: seg_code = 7'h06;
            4'h2: seg_code = 7'h5B;
            4'h3: seg_code = 7'h4F;
            4'h4: seg_code = 7'h66;
            4'h5: seg_code = 7'h6D;
            4'h6: seg_code = 7'h7D;
            4'h7: seg_code = 7'h07;
            4'h8: seg_code = 7'h7F;
            4'h9: seg_code = 7'h6F;
            4'hA: seg_code = 7'h77;
            4'hB: seg_code = 7'h7C;
            4'hC: seg_code = 7'h39;
            4'hD: seg_code = 7'h5E;
            4'hE: seg_code = 7'h79;
            default: seg_code = 7'h71;
        endcase
    endfunction

    // Full 12-bit bus for digit k: one-hot enable, dp, segments, with
    // leading-zero blanking (digit 0 is never blanked; dp survives blanking).
    function automatic logic [11:0] digi_bus(input logic [1:0]  k,
                                             input logic [15:0] v,
                                             input logic [3:0]  dp,
                                             input logic        blank_lz);
        logic       z3, z2, z1;
        logic [3:0] nib;
        logic       blank;
        logic [6:0] seg;
        logic [11:0] bus_hi;
        z3 = (v[15:12] == 4'h0);
        z2 = z3 && (v[11:8] == 4'h0);
        z1 = z2 && (v[7:4] == 4'h0);
        case (k)
            2'd0: begin nib = v[3:0];   blank = 1'b0;            end
            2'd1: begin nib = v[7:4];   blank = blank_lz && z1;  end
            2'd2: begin nib = v[11:8];  blank = blank_lz && z2;  end
            default: begin nib = v[15:12]; blank = blank_lz && z3; end
        endcase
        seg    = blank ? 7'h00 : seg_code(nib);
        bus_hi = {4'b0001 << k, dp[k], seg};
        digi_bus = ACTIVE_LOW ? ~bus_hi : bus_hi;
    endfunction

    // Next-state: divider, index, shadow/display handoff and output encoding.
    always_comb begin
        tick           = (cnt == CNT_LAST);
        commit         = tick && (idx == 2'd3) && pending;
        cnt_nxt        = tick ? '0 : cnt + CNT_W'(1);
        idx_nxt        = tick ? idx + 2'd1 : idx;
        shadow_val_nxt = shadow_val;
        shadow_dp_nxt  = shadow_dp;
        disp_val_nxt   = disp_val;
        disp_dp_nxt    = disp_dp;
        pending_nxt    = pending;
        if (commit) begin
            disp_val_nxt = shadow_val;
            disp_dp_nxt  = shadow_dp;
            pending_nxt  = 1'b0;
        end
        // A load on the commit tick wins: the old shadow is shown, the new
        // one waits for the next frame.
        if (bus.iLoad) begin
            shadow_val_nxt = bus.iValue;
            shadow_dp_nxt  = bus.iDP;
            pending_nxt    = 1'b1;
        end
        digi_nxt = digi_bus(idx_nxt, disp_val_nxt, disp_dp_nxt, bus.iBlankLZ);
    end

    // State and registered outputs, cleared asynchronously by iRst.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            shadow_val <= 16'h0000;
            shadow_dp  <= 4'h0;
            disp_val   <= 16'h0000;
            disp_dp    <= 4'h0;
            pending    <= 1'b0;
            digi       <= DIGI_RST;
            frame      <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shadow_val <= shadow_val_nxt;
            shadow_dp  <= shadow_dp_nxt;
            disp_val   <= disp_val_nxt;
            disp_dp    <= disp_dp_nxt;
            pending    <= pending_nxt;
            digi       <= digi_nxt;
            frame      <= commit;
        end
    end

    assign bus.oDigi  = digi;
    assign bus.oFrame = frame;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with REFRESH_DIV=4, ACTIVE_LOW=1.
module tb_seg7_scan;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   cyc;
    int   frame_at;
    int   frames_seen;

    seg7_scan_if bus();

    seg7_scan #(.REFRESH_DIV(4), .ACTIVE_LOW(1)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Advance until cyc reaches 'upto', checking the digit bus against the
    // hand-computed table for the active digit and oFrame against frame_at.
    task automatic run(input int upto, input logic [11:0] t0, input logic [11:0] t1,
                       input logic [11:0] t2, input logic [11:0] t3);
        logic [11:0] tab [4];
        tab[0] = t0; tab[1] = t1; tab[2] = t2; tab[3] = t3;
        while (cyc < upto) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            check("digi", {20'h0, bus.oDigi}, {20'h0, tab[(cyc / 4) % 4]});
            check("frame", {31'h0, bus.oFrame}, {31'h0, (cyc == frame_at)});
            if (bus.oFrame) frames_seen++;
        end
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dp);
        bus.iValue = v;
        bus.iDP    = dp;
        bus.iLoad  = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; frame_at = -1; frames_seen = 0;
        rst = 1'b1;
        bus.iValue = 16'h0; bus.iDP = 4'h0; bus.iLoad = 1'b0; bus.iBlankLZ = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_digi", {20'h0, bus.oDigi}, 32'hEC0);
        check("rst_frame", {31'h0, bus.oFrame}, 32'h0);
        rst = 1'b0;
        cyc = 0;

        // Plain scan of an all-zero display.
        run(18, 12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0);

        // Mid-frame load of 12AF: unchanged until the wrap, then one frame pulse.
        load(16'h12AF, 4'b0000);
        run(19, 12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0);
        bus.iLoad = 1'b0;
        run(31, 12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0);
        frame_at = 32;
        run(50, 12'hE8E, 12'hD88, 12'hBA4, 12'h7F9);

        // Leading-zero blanking with dp on a blanked digit.
        bus.iBlankLZ = 1'b1;
        load(16'h0007, 4'b0100);
        run(51, 12'hE8E, 12'hD88, 12'hBA4, 12'h7F9);
        bus.iLoad = 1'b0;
        run(63, 12'hE8E, 12'hD88, 12'hBA4, 12'h7F9);
        frame_at = 64;
        run(85, 12'hEF8, 12'hDFF, 12'hB7F, 12'h7FF);

        // B pending, A loaded on the commit tick: B this frame, A next frame.
        frames_seen = 0;
        load(16'h3456, 4'b0000);
        run(86, 12'hEF8, 12'hDFF, 12'hB7F, 12'h7FF);
        bus.iLoad = 1'b0;
        run(95, 12'hEF8, 12'hDFF, 12'hB7F, 12'h7FF);
        load(16'hCDE8, 4'b0001);
        frame_at = 96;
        run(96, 12'hE82, 12'hD92, 12'hB99, 12'h7B0);
        bus.iLoad = 1'b0;
        run(111, 12'hE82, 12'hD92, 12'hB99, 12'h7B0);
        frame_at = 112;
        run(130, 12'hE00, 12'hD86, 12'hBA1, 12'h7C6);
        check("two_frames", frames_seen, 32'd2);

        // Reset during digit 2 with a load pending discards the shadow.
        load(16'h8888, 4'b1111);
        run(132, 12'hE00, 12'hD86, 12'hBA1, 12'h7C6);
        bus.iLoad = 1'b0;
        run(137, 12'hE00, 12'hD86, 12'hBA1, 12'h7C6);
        check("dig2_before_rst", {20'h0, bus.oDigi}, 32'hBA1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_digi", {20'h0, bus.oDigi}, 32'hEC0);
        check("async_rst_frame", {31'h0, bus.oFrame}, 32'h0);
        bus.iBlankLZ = 1'b0;
        @(negedge clk);
        check("held_rst_digi", {20'h0, bus.oDigi}, 32'hEC0);
        rst = 1'b0;
        cyc = 0;
        frame_at = -1;
        frames_seen = 0;
        run(40, 12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0);
        check("no_frame_after_rst", frames_seen, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
